// File: rtl/decode_dispatch_ctrl_pkg.sv
// Shared decode typedefs and constants for the decode/dispatch front end.
package decode_dispatch_ctrl_pkg;

  localparam int unsigned DECODE_WIDTH = 4;

  typedef logic [2:0] slot_cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } DECODE_REQUIRE;

  typedef struct packed {
    DECODE_REQUIRE req;
    logic [5:0]    rob_tag;
  } ISSUE_QUEUE_ELEMENT;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/decode_dispatch_ctrl_lane_compactor.sv
// Packs the valid lanes of a fetch bundle down to lane 0, preserving lane order.
module lane_compactor
  import decode_dispatch_ctrl_pkg::*;
(
  input  logic [3:0]          mask,
  input  DECODE_REQUIRE [3:0] bundle,
  output DECODE_REQUIRE [3:0] compacted,
  output slot_cnt_t           count
);

  slot_cnt_t k;

  always_comb begin
    compacted = '0;
    k         = '0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      if (mask[i]) begin
        compacted[k[1:0]] = bundle[i];
        k = k + 3'd1;
      end
    end
    count = k;
  end

endmodule

// File: rtl/decode_dispatch_ctrl.sv
// Single-bundle buffer in front of the 4-wide decoders; meters pushes into the
// issue queue by its free space and shifts undispatched lanes down.
module decode_dispatch_ctrl
  import decode_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_valid,
  input  logic [LANES-1:0]          fetch_mask,
  input  DECODE_REQUIRE [LANES-1:0] fetch_bundle,
  output logic                      fetch_ready,
  input  logic                      flush,
  output DECODE_REQUIRE [LANES-1:0] decode_require,
  output logic [LANES-1:0]          decode_lane_valid,
  input  logic [2:0]                iq_size_left,
  output logic [2:0]                issue_queue_push_number,
  output logic [STALL_CNT_W-1:0]    stall_cycles
);

  DECODE_REQUIRE [LANES-1:0] buf_q, buf_n, compacted;
  slot_cnt_t                 cnt_q, cnt_n, fetch_cnt, space, push;
  dispatch_state_t           state_q, state_n;
  logic                      accept;

  lane_compactor u_compactor (
    .mask      (fetch_mask),
    .bundle    (fetch_bundle),
    .compacted (compacted),
    .count     (fetch_cnt)
  );

  always_comb begin
    space       = (iq_size_left > 3'd4) ? 3'd4 : iq_size_left;
    push        = flush ? '0 : ((cnt_q < space) ? cnt_q : space);
    // Ready as soon as the held entries fully drain this cycle.
    fetch_ready = !flush && (cnt_q == push);
    accept      = fetch_valid && fetch_ready;

    issue_queue_push_number = push;
    decode_require          = buf_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      decode_lane_valid[i] = (i < 32'(cnt_q));
    end
  end

  always_comb begin
    int unsigned src;
    src     = 0;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    state_n = state_q;
    if (flush) begin
      buf_n = '0;
      cnt_n = '0;
    end else if (accept) begin
      buf_n = compacted;
      cnt_n = fetch_cnt;
    end else begin
      case (state_q)
        HOLD: begin
          for (int unsigned j = 0; j < LANES; j++) begin
            src      = j + 32'(push);
            buf_n[j] = (src < LANES) ? buf_q[src[1:0]] : '0;
          end
          cnt_n = cnt_q - push;
        end
        default: ;
      endcase
    end
    state_n = (cnt_n == '0) ? EMPTY : HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      cnt_q        <= '0;
      buf_q        <= '0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      buf_q   <= buf_n;
      if ((cnt_q != '0) && (push == '0) && !flush && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
    end
  end

  a_push_le_cnt: assert property (@(posedge clk) disable iff (!rst_n) push <= cnt_q);
  a_cnt_le_4:    assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 3'd4);
  a_valid_contig: assert property (@(posedge clk) disable iff (!rst_n)
    ((decode_lane_valid + 4'd1) & decode_lane_valid) == 4'd0);
  a_state_cnt:   assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == EMPTY) == (cnt_q == '0));

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Randomized and directed checks of decode_dispatch_ctrl against a queue-based model.
module tb_decode_dispatch_ctrl;
  import decode_dispatch_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                fetch_valid = 1'b0;
  logic [3:0]          fetch_mask = '0;
  DECODE_REQUIRE [3:0] fetch_bundle = '0;
  logic                fetch_ready;
  logic                flush = 1'b0;
  DECODE_REQUIRE [3:0] decode_require;
  logic [3:0]          decode_lane_valid;
  logic [2:0]          iq_size_left = '0;
  logic [2:0]          issue_queue_push_number;
  logic [31:0]         stall_cycles;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  DECODE_REQUIRE q[$];
  logic [31:0]   m_stall = '0;

  decode_dispatch_ctrl #(.LANES(4), .STALL_CNT_W(32)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .fetch_valid             (fetch_valid),
    .fetch_mask              (fetch_mask),
    .fetch_bundle            (fetch_bundle),
    .fetch_ready             (fetch_ready),
    .flush                   (flush),
    .decode_require          (decode_require),
    .decode_lane_valid       (decode_lane_valid),
    .iq_size_left            (iq_size_left),
    .issue_queue_push_number (issue_queue_push_number),
    .stall_cycles            (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic DECODE_REQUIRE [3:0] rand_bundle();
    DECODE_REQUIRE [3:0] b;
    for (int i = 0; i < 4; i++) begin
      b[i].pc    = $urandom;
      b[i].instr = $urandom;
    end
    return b;
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic fv, input logic [3:0] m, input DECODE_REQUIRE [3:0] b,
                      input logic fl, input logic [2:0] iq);
    int unsigned sz, space, push;
    logic ready;
    logic [4:0] ve;
    @(negedge clk);
    fetch_valid  = fv;
    fetch_mask   = m;
    fetch_bundle = b;
    flush        = fl;
    iq_size_left = iq;
    #1;
    sz    = q.size();
    space = (iq > 3'd4) ? 4 : int'(iq);
    push  = fl ? 0 : ((sz < space) ? sz : space);
    ready = !fl && (sz == push);
    ve    = (5'd1 << sz) - 5'd1;
    check("push", 64'(issue_queue_push_number), 64'(push));
    check("ready", 64'(fetch_ready), 64'(ready));
    check("lane_valid", 64'(decode_lane_valid), 64'(ve[3:0]));
    check("stall", 64'(stall_cycles), 64'(m_stall));
    for (int i = 0; i < 4; i++)
      check($sformatf("lane%0d", i), decode_require[i], (i < int'(sz)) ? q[i] : '0);
    if (sz > 0 && push == 0 && !fl && m_stall != '1) m_stall++;
    if (fl) q.delete();
    else if (fv && ready) begin
      q.delete();
      for (int i = 0; i < 4; i++) if (m[i]) q.push_back(b[i]);
    end else repeat (push) void'(q.pop_front());
  endtask

  initial begin
    DECODE_REQUIRE [3:0] b, b2;
    DECODE_REQUIRE       a_ref, b_ref;
    logic [31:0]         base;

    #2 rst_n = 1'b0;
    #1;
    check("rst_push", 64'(issue_queue_push_number), 64'd0);
    check("rst_valid", 64'(decode_lane_valid), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0000, '0, 1'b0, 3'd0);
    check("rst_ready", 64'(fetch_ready), 64'd1);

    // Full bundle with plenty of space
    b = rand_bundle();
    step(1'b1, 4'b1111, b, 1'b0, 3'd7);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd7);
    check("full_push", 64'(issue_queue_push_number), 64'd4);
    check("full_valid", 64'(decode_lane_valid), 64'hf);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd7);
    check("full_empty", 64'(decode_lane_valid), 64'd0);

    // Sparse mask
    b = rand_bundle();
    a_ref = b[1];
    b_ref = b[3];
    step(1'b1, 4'b1010, b, 1'b0, 3'd7);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd2);
    check("sparse_l0", decode_require[0], a_ref);
    check("sparse_l1", decode_require[1], b_ref);
    check("sparse_valid", 64'(decode_lane_valid), 64'h3);
    check("sparse_push", 64'(issue_queue_push_number), 64'd2);

    // Partial dispatch 1, 2, 1
    base = m_stall;
    b = rand_bundle();
    step(1'b1, 4'b1111, b, 1'b0, 3'd0);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd1);
    check("part1_push", 64'(issue_queue_push_number), 64'd1);
    check("part1_ready", 64'(fetch_ready), 64'd0);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd2);
    check("part2_push", 64'(issue_queue_push_number), 64'd2);
    check("part2_l0", decode_require[0], b[1]);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd4);
    check("part3_push", 64'(issue_queue_push_number), 64'd1);
    check("part3_ready", 64'(fetch_ready), 64'd1);
    check("part3_l0", decode_require[0], b[3]);
    check("part_stall", 64'(stall_cycles), 64'(base));

    // Zero space for five cycles, then drain while loading a new bundle
    b = rand_bundle();
    step(1'b1, 4'b0111, b, 1'b0, 3'd0);
    base = m_stall;
    repeat (5) begin
      step(1'b1, 4'b1111, rand_bundle(), 1'b0, 3'd0);
      check("zs_push", 64'(issue_queue_push_number), 64'd0);
      check("zs_ready", 64'(fetch_ready), 64'd0);
      check("zs_l2", decode_require[2], b[2]);
    end
    b2 = rand_bundle();
    step(1'b1, 4'b1111, b2, 1'b0, 3'd7);
    check("zs_stall", 64'(stall_cycles), 64'(base + 32'd5));
    check("zs_drain", 64'(issue_queue_push_number), 64'd3);

    // Flush with fetch offering a bundle
    step(1'b1, 4'b1111, rand_bundle(), 1'b1, 3'd7);
    check("fl_push", 64'(issue_queue_push_number), 64'd0);
    check("fl_ready", 64'(fetch_ready), 64'd0);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd7);
    check("fl_valid", 64'(decode_lane_valid), 64'd0);
    check("fl_after_ready", 64'(fetch_ready), 64'd1);

    // Stall once so the counter is nonzero, then reset asynchronously mid-HOLD
    step(1'b1, 4'b1111, rand_bundle(), 1'b0, 3'd0);
    step(1'b0, 4'b0000, '0, 1'b0, 3'd0);
    @(negedge clk);
    fetch_valid  = 1'b0;
    flush        = 1'b0;
    iq_size_left = 3'd7;
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(decode_lane_valid), 64'd0);
    check("arst_push", 64'(issue_queue_push_number), 64'd0);
    check("arst_stall", 64'(stall_cycles), 64'd0);
    q.delete();
    m_stall = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0000, '0, 1'b0, 3'd7);
    check("arst_ready", 64'(fetch_ready), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(3) != 0), 4'($urandom), rand_bundle(),
           ($urandom_range(15) == 0), 3'($urandom_range(7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
